// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer round sequencer: state encoding
// and default timing limits in milliseconds.
package reaction_pkg;

    localparam int MS_W_DEF       = 14;
    localparam int MAX_MS_DEF     = 9999;
    localparam int NO_RESP_MS_DEF = 2000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LIGHTS = 3'd1,
        ST_DELAY  = 3'd2,
        ST_REACT  = 3'd3,
        ST_SHOW   = 3'd4,
        ST_FOUL   = 3'd5
    } state_t;

endpackage

// File: rtl/key_edge.sv
// Press detector for an active-low, already synchronised key.
// held_r stores the active-high "key was down last cycle" bit. It resets to
// 1 so that a key held down through reset is treated as already pressed and
// produces no press until it has been released and pressed again.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic held_r;

    // Track the previous-cycle pressed state of the key.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_r <= 1'b1;
        end else begin
            held_r <= ~key_n;
        end
    end

    assign press = ~key_n & ~held_r;

endmodule

// File: rtl/reaction_ctrl.sv
// Round sequencer for the reaction-timer game: starts the light sequencer,
// loads the random delay, measures reaction time after lights-out, flags jump
// starts and no-response rounds, and keeps the best time of the session.
import reaction_pkg::*;

module reaction_ctrl #(
    parameter int MS_W       = MS_W_DEF,
    parameter int MAX_MS     = MAX_MS_DEF,
    parameter int NO_RESP_MS = NO_RESP_MS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick_ms,
    input  logic            trigger,
    input  logic            react_key,
    input  logic            start_delay,
    input  logic            time_out,
    output logic            start_lights,
    output logic            load_delay,
    output logic            react_led,
    output logic [MS_W-1:0] result_ms,
    output logic            result_valid,
    output logic [MS_W-1:0] best_ms,
    output logic            best_valid,
    output logic            foul,
    output logic            no_resp
);

    localparam logic [MS_W-1:0] MAX_C     = MS_W'(MAX_MS);
    localparam logic [MS_W-1:0] NO_RESP_C = MS_W'(NO_RESP_MS);

    state_t          state_r;
    state_t          state_nxt_s;
    logic            trig_press_s;
    logic            react_press_s;
    logic            start_round_s;
    logic            load_s;
    logic            clr_cnt_s;
    logic            hit_s;
    logic            miss_s;
    logic            foul_ev_s;

    logic [MS_W-1:0] cnt_r;
    logic            start_lights_r;
    logic            load_delay_r;
    logic            react_led_r;
    logic [MS_W-1:0] result_ms_r;
    logic            result_valid_r;
    logic [MS_W-1:0] best_ms_r;
    logic            best_valid_r;
    logic            foul_r;
    logic            no_resp_r;

    key_edge u_trig_edge (
        .clk   (clk),
        .reset (reset),
        .key_n (trigger),
        .press (trig_press_s)
    );

    key_edge u_react_edge (
        .clk   (clk),
        .reset (reset),
        .key_n (react_key),
        .press (react_press_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and one-cycle event strobes; a react press wins over
    // a simultaneous start_delay/time_out (foul) and over the window expiry.
    always_comb begin
        state_nxt_s   = state_r;
        start_round_s = 1'b0;
        load_s        = 1'b0;
        clr_cnt_s     = 1'b0;
        hit_s         = 1'b0;
        miss_s        = 1'b0;
        foul_ev_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_SHOW, ST_FOUL: begin
                if (trig_press_s) begin
                    state_nxt_s   = ST_LIGHTS;
                    start_round_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LIGHTS: begin
                if (react_press_s) begin
                    state_nxt_s = ST_FOUL;
                    foul_ev_s   = 1'b1;
                end else if (start_delay) begin
                    state_nxt_s = ST_DELAY;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_LIGHTS;
                end
            end
            ST_DELAY: begin
                if (react_press_s) begin
                    state_nxt_s = ST_FOUL;
                    foul_ev_s   = 1'b1;
                end else if (time_out) begin
                    state_nxt_s = ST_REACT;
                    clr_cnt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_DELAY;
                end
            end
            ST_REACT: begin
                if (react_press_s) begin
                    state_nxt_s = ST_SHOW;
                    hit_s       = 1'b1;
                end else if (cnt_r == NO_RESP_C) begin
                    state_nxt_s = ST_SHOW;
                    miss_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_REACT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Reaction counter: cleared on lights-out, counts ms in REACT, saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {MS_W{1'b0}};
        end else if (clr_cnt_s) begin
            cnt_r <= {MS_W{1'b0}};
        end else if ((state_r == ST_REACT) && tick_ms && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + MS_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered pulse and indicator outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_lights_r <= 1'b0;
            load_delay_r   <= 1'b0;
            react_led_r    <= 1'b0;
        end else begin
            start_lights_r <= start_round_s;
            load_delay_r   <= load_s;
            react_led_r    <= (state_nxt_s == ST_REACT);
        end
    end

    // Round outcome registers: result, best time and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_ms_r    <= {MS_W{1'b0}};
            result_valid_r <= 1'b0;
            best_ms_r      <= MAX_C;
            best_valid_r   <= 1'b0;
            foul_r         <= 1'b0;
            no_resp_r      <= 1'b0;
        end else if (start_round_s) begin
            result_valid_r <= 1'b0;
            foul_r         <= 1'b0;
            no_resp_r      <= 1'b0;
        end else if (foul_ev_s) begin
            foul_r         <= 1'b1;
            result_valid_r <= 1'b0;
        end else if (hit_s) begin
            result_ms_r    <= cnt_r;
            result_valid_r <= 1'b1;
            if (!best_valid_r || (cnt_r < best_ms_r)) begin
                best_ms_r    <= cnt_r;
                best_valid_r <= 1'b1;
            end else begin
                best_ms_r    <= best_ms_r;
                best_valid_r <= best_valid_r;
            end
        end else if (miss_s) begin
            no_resp_r      <= 1'b1;
            result_ms_r    <= MAX_C;
            result_valid_r <= 1'b0;
        end else begin
            result_ms_r    <= result_ms_r;
            result_valid_r <= result_valid_r;
        end
    end

    assign start_lights = start_lights_r;
    assign load_delay   = load_delay_r;
    assign react_led    = react_led_r;
    assign result_ms    = result_ms_r;
    assign result_valid = result_valid_r;
    assign best_ms      = best_ms_r;
    assign best_valid   = best_valid_r;
    assign foul         = foul_r;
    assign no_resp      = no_resp_r;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: stimulus tasks push the expected output
// vector and the cycle in which it must appear; a monitor pops an entry every
// time any DUT output changes and compares both.
module tb_reaction_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_ms = 1'b0;
    logic        trigger = 1'b1;
    logic        react_key = 1'b1;
    logic        start_delay = 1'b0;
    logic        time_out = 1'b0;
    logic        start_lights;
    logic        load_delay;
    logic        react_led;
    logic [13:0] result_ms;
    logic        result_valid;
    logic [13:0] best_ms;
    logic        best_valid;
    logic        foul;
    logic        no_resp;

    reaction_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick_ms      (tick_ms),
        .trigger      (trigger),
        .react_key    (react_key),
        .start_delay  (start_delay),
        .time_out     (time_out),
        .start_lights (start_lights),
        .load_delay   (load_delay),
        .react_led    (react_led),
        .result_ms    (result_ms),
        .result_valid (result_valid),
        .best_ms      (best_ms),
        .best_valid   (best_valid),
        .foul         (foul),
        .no_resp      (no_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [34:0] vec;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;

    // expected output state (reset values)
    logic        e_sl = 1'b0, e_ld = 1'b0, e_led = 1'b0, e_rv = 1'b0;
    logic        e_bv = 1'b0, e_foul = 1'b0, e_nr = 1'b0;
    logic [13:0] e_res = 14'd0;
    logic [13:0] e_best = 14'd9999;

    function automatic logic [34:0] pk(logic sl, logic ld, logic led, logic [13:0] res,
                                       logic rv, logic [13:0] best, logic bv,
                                       logic fl, logic nr);
        return {sl, ld, led, res, rv, best, bv, fl, nr};
    endfunction

    function automatic logic [34:0] dut_vec();
        return pk(start_lights, load_delay, react_led, result_ms, result_valid,
                  best_ms, best_valid, foul, no_resp);
    endfunction

    task automatic push(input int c);
        exp_t e;
        e.cyc = c;
        e.vec = pk(e_sl, e_ld, e_led, e_res, e_rv, e_best, e_bv, e_foul, e_nr);
        q.push_back(e);
    endtask

    // monitor: every output change must match the next scoreboard entry
    logic [34:0] prev_vec;
    logic        armed = 1'b0;
    always @(negedge clk) begin
        logic [34:0] act;
        exp_t        e;
        if (mon_en) begin
            act = dut_vec();
            if (!armed) begin
                prev_vec = act;
                armed = 1'b1;
            end else if (act !== prev_vec) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d act=%h", cyc, act);
                end else begin
                    e = q.pop_front();
                    if ((e.vec !== act) || (e.cyc != cyc)) begin
                        bad++;
                        $display("FAIL out_event cyc=%0d exp_cyc=%0d act=%h exp=%h",
                                 cyc, e.cyc, act, e.vec);
                    end
                end
                prev_vec = act;
            end
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick1();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick1();
    endtask

    task automatic trig_press();
        int c;
        c = cyc;
        e_sl = 1'b1; e_foul = 1'b0; e_nr = 1'b0; e_rv = 1'b0;
        push(c + 1);
        e_sl = 1'b0;
        push(c + 2);
        trigger = 1'b0;
        tick1();
        trigger = 1'b1;
    endtask

    task automatic pulse_sd();
        int c;
        c = cyc;
        e_ld = 1'b1;
        push(c + 1);
        e_ld = 1'b0;
        push(c + 2);
        start_delay = 1'b1;
        tick1();
        start_delay = 1'b0;
    endtask

    task automatic pulse_to();
        e_led = 1'b1;
        push(cyc + 1);
        time_out = 1'b1;
        tick1();
        time_out = 1'b0;
    endtask

    // n ms ticks two cycles apart; returns at the cycle right after the last tick
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_ms = 1'b1;
            tick1();
            tick_ms = 1'b0;
            if (i < n - 1) tick1();
        end
    endtask

    task automatic react_hit(input int n, input int exp_best, input logic with_tick);
        e_led = 1'b0; e_res = 14'(n); e_rv = 1'b1; e_best = 14'(exp_best); e_bv = 1'b1;
        push(cyc + 1);
        react_key = 1'b0;
        tick_ms = with_tick;
        tick1();
        react_key = 1'b1;
        tick_ms = 1'b0;
    endtask

    task automatic run_to_react();
        int c0;
        c0 = cyc;
        trig_press();
        wait_until(c0 + 20);
        pulse_sd();
        wait_until(c0 + 50);
        pulse_to();
    endtask

    task automatic round(input int n, input int exp_best, input logic with_tick);
        run_to_react();
        ticks(n);
        react_hit(n, exp_best, with_tick);
        idle(5);
    endtask

    initial begin
        int c0;
        int c;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut_vec() !== pk(1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 14'd9999, 1'b0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_state act=%h", dut_vec());
        end
        mon_en = 1'b1;
        reset = 1'b0;
        idle(5);

        // rounds 1-3: best tracking; round 3 press lands on a tick
        round(237, 237, 1'b0);
        round(412, 237, 1'b0);
        round(150, 150, 1'b1);

        // no response for the whole window
        run_to_react();
        ticks(2000);
        e_led = 1'b0; e_nr = 1'b1; e_res = 14'd9999; e_rv = 1'b0;
        push(cyc + 1);
        idle(6);

        // press in the same cycle the counter reaches the window limit
        round(2000, 150, 1'b0);

        // jump start during LIGHTS; later start_delay must not load the delay
        c0 = cyc;
        trig_press();
        wait_until(c0 + 10);
        e_foul = 1'b1;
        push(cyc + 1);
        react_key = 1'b0;
        tick1();
        react_key = 1'b1;
        wait_until(c0 + 20);
        start_delay = 1'b1;
        tick1();
        start_delay = 1'b0;
        idle(10);

        // react press on the same cycle as time_out
        c0 = cyc;
        trig_press();
        wait_until(c0 + 20);
        pulse_sd();
        wait_until(c0 + 50);
        e_foul = 1'b1;
        push(cyc + 1);
        time_out = 1'b1;
        react_key = 1'b0;
        tick1();
        time_out = 1'b0;
        react_key = 1'b1;
        idle(10);

        // react key held low through lights-out: a single foul
        c0 = cyc;
        trig_press();
        wait_until(c0 + 20);
        pulse_sd();
        wait_until(c0 + 40);
        e_foul = 1'b1;
        push(cyc + 1);
        react_key = 1'b0;
        tick1();
        wait_until(c0 + 50);
        time_out = 1'b1;
        tick1();
        time_out = 1'b0;
        wait_until(c0 + 70);
        react_key = 1'b1;
        idle(5);

        // trigger held low: one start pulse; then reset in REACT at count 80
        c0 = cyc;
        e_sl = 1'b1; e_foul = 1'b0; e_nr = 1'b0; e_rv = 1'b0;
        push(c0 + 1);
        e_sl = 1'b0;
        push(c0 + 2);
        trigger = 1'b0;
        idle(30);
        trigger = 1'b1;
        wait_until(c0 + 40);
        pulse_sd();
        wait_until(c0 + 60);
        pulse_to();
        ticks(80);
        c = cyc;
        e_led = 1'b0; e_res = 14'd0; e_rv = 1'b0; e_best = 14'd9999;
        e_bv = 1'b0; e_foul = 1'b0; e_nr = 1'b0;
        push(c + 1);
        reset = 1'b1;
        trigger = 1'b0;
        react_key = 1'b0;
        idle(3);
        reset = 1'b0;
        idle(10);
        trigger = 1'b1;
        react_key = 1'b1;
        idle(5);

        // first round after reset: best restarts from scratch
        round(300, 300, 1'b0);

        idle(10);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_events act=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
